// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: RAW hazard detection against
// in-flight EXE/MEM destinations, memory wait sequencing with timeout, branch flush.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 4,
    parameter bit FWD_EN     = 1'b1,
    parameter int WAIT_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  freeze_front,
    output logic                  flush_if,
    output logic                  flush_id,
    output logic                  stall_back,
    output logic                  mem_err
);
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    typedef struct packed {
        logic                  valid;
        logic                  wb;
        logic                  load;
        logic [REG_ADDR_W-1:0] dest;
    } slot_t;

    state_t           state;
    slot_t            exe_slot;
    slot_t            mem_slot;
    logic [CNT_W-1:0] wait_cnt;

    logic match_exe;
    logic match_mem;
    logic hazard;
    logic mem_stall;

    assign match_exe = exe_slot.valid & exe_slot.wb & id_valid &
                       ((id_src1 == exe_slot.dest) | (id_two_src & (id_src2 == exe_slot.dest)));
    assign match_mem = mem_slot.valid & mem_slot.wb & id_valid &
                       ((id_src1 == mem_slot.dest) | (id_two_src & (id_src2 == mem_slot.dest)));

    always_comb begin
        hazard = 1'b0;
        if (FWD_EN) hazard = match_exe & exe_slot.load;
        else        hazard = match_exe | match_mem;
    end

    always_comb begin
        mem_stall = 1'b0;
        case (state)
            RUN:      mem_stall = mem_req & ~mem_ready;
            MEM_WAIT: mem_stall = ~mem_ready;
            ERR:      mem_stall = 1'b1;
            default:  mem_stall = 1'b0;
        endcase
    end

    // Outputs are forced low for the whole reset assertion, not just after the edge.
    always_comb begin
        freeze_front = 1'b0;
        flush_if     = 1'b0;
        flush_id     = 1'b0;
        stall_back   = 1'b0;
        mem_err      = 1'b0;
        if (rst) begin
            mem_err = (state == ERR);
            if (mem_stall) begin
                freeze_front = 1'b1;
                stall_back   = 1'b1;
            end else if (branch_taken) begin
                flush_if = 1'b1;
                flush_id = 1'b1;
            end else if (hazard) begin
                freeze_front = 1'b1;
                flush_id     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            exe_slot <= '0;
            mem_slot <= '0;
            wait_cnt <= '0;
        end else begin
            if (!mem_stall) begin
                mem_slot <= exe_slot;
                if (flush_id) exe_slot <= '0;
                else          exe_slot <= '{id_valid, id_wb_en, id_mem_r_en, id_dest};
            end
            case (state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_W'(WAIT_MAX)) begin
                        state <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ERR:     state <= ERR;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: forwarding and non-forwarding instances
// driven in parallel, checked against a vector table, hand sequences and a reference model.
module tb_pipe_hazard_ctrl;
    localparam int W  = 4;
    localparam int WM = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic idv, two, wb, ld, br, req, rdy;
    logic [W-1:0] s1, s2, dst;

    logic ff1, fi1, fd1, sb1, me1;
    logic ff0, fi0, fd0, sb0, me0;
    logic [4:0] out1, out0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(W), .FWD_EN(1'b1), .WAIT_MAX(WM)) u_fwd1 (
        .clk(clk), .rst(rst), .id_valid(idv), .id_src1(s1), .id_src2(s2),
        .id_two_src(two), .id_wb_en(wb), .id_mem_r_en(ld), .id_dest(dst),
        .branch_taken(br), .mem_req(req), .mem_ready(rdy),
        .freeze_front(ff1), .flush_if(fi1), .flush_id(fd1), .stall_back(sb1), .mem_err(me1));

    pipe_hazard_ctrl #(.REG_ADDR_W(W), .FWD_EN(1'b0), .WAIT_MAX(WM)) u_fwd0 (
        .clk(clk), .rst(rst), .id_valid(idv), .id_src1(s1), .id_src2(s2),
        .id_two_src(two), .id_wb_en(wb), .id_mem_r_en(ld), .id_dest(dst),
        .branch_taken(br), .mem_req(req), .mem_ready(rdy),
        .freeze_front(ff0), .flush_if(fi0), .flush_id(fd0), .stall_back(sb0), .mem_err(me0));

    // Packed view: {freeze_front, flush_if, flush_id, stall_back, mem_err}
    assign out1 = {ff1, fi1, fd1, sb1, me1};
    assign out0 = {ff0, fi0, fd0, sb0, me0};

    typedef struct {
        logic idv, two, wb, ld, br, req, rdy;
        logic [W-1:0] s1, s2, dst;
        logic [4:0] exp1, exp0;
        logic chk1, chk0;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic t, input logic w, input logic l, input logic [W-1:0] d,
                                input logic bt, input logic rq, input logic rd,
                                input logic [4:0] e1, input logic [4:0] e0,
                                input logic c1, input logic c0);
        vec_t r;
        r.idv = v; r.s1 = a; r.s2 = b; r.two = t; r.wb = w; r.ld = l; r.dst = d;
        r.br = bt; r.req = rq; r.rdy = rd;
        r.exp1 = e1; r.exp0 = e0; r.chk1 = c1; r.chk0 = c0;
        return r;
    endfunction

    // Reference model: in-flight instructions per variant (index = FWD_EN),
    // count of consecutive memory stall cycles, sticky error.
    typedef struct packed { logic v, wb, ld; logic [W-1:0] d; } slot_t;
    slot_t m_exe[2];
    slot_t m_mem[2];
    int    m_n;
    bit    m_err;

    function automatic void model_reset();
        for (int f = 0; f < 2; f++) begin m_exe[f] = '0; m_mem[f] = '0; end
        m_n = 0;
        m_err = 1'b0;
    endfunction

    function automatic logic hit(input slot_t s);
        return s.v && s.wb && idv && (s1 == s.d || (two && s2 == s.d));
    endfunction

    function automatic logic m_stall();
        return m_err || (!rdy && (req || m_n > 0));
    endfunction

    function automatic logic m_hazard(input int f);
        if (f == 1) return hit(m_exe[1]) && m_exe[1].ld;
        return hit(m_exe[0]) || hit(m_mem[0]);
    endfunction

    function automatic logic [4:0] model_out(input int f);
        if (m_stall()) return {4'b1001, m_err};
        if (br) return 5'b01100;
        if (m_hazard(f)) return 5'b10100;
        return 5'b00000;
    endfunction

    function automatic void model_advance();
        logic st;
        st = m_stall();
        for (int f = 0; f < 2; f++) begin
            if (!st) begin
                logic fl;
                fl = br || m_hazard(f);
                m_mem[f] = m_exe[f];
                m_exe[f] = fl ? slot_t'('0) : slot_t'({idv, wb, ld, dst});
            end
        end
        if (st) begin
            m_n++;
            if (m_n > WM) m_err = 1'b1;
        end else begin
            m_n = 0;
        end
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        idv = v.idv; s1 = v.s1; s2 = v.s2; two = v.two; wb = v.wb; ld = v.ld;
        dst = v.dst; br = v.br; req = v.req; rdy = v.rdy;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 5'b0, 0, 0));
    endtask

    // Called at posedge+1: apply, check before the next edge, advance model, move on.
    task automatic step(input vec_t v, input string tag);
        drive(v);
        #2;
        check({tag, "/model_fwd1"}, out1, model_out(1));
        check({tag, "/model_fwd0"}, out0, model_out(0));
        if (v.chk1) check({tag, "/exp_fwd1"}, out1, v.exp1);
        if (v.chk0) check({tag, "/exp_fwd0"}, out0, v.exp0);
        model_advance();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse between edges, outputs checked while it is held.
    task automatic reset_pulse(input string tag);
        #2 rst = 1'b0;
        #1;
        check({tag, "/rst_fwd1"}, out1, 5'b0);
        check({tag, "/rst_fwd0"}, out0, 5'b0);
        idle();
        model_reset();
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        model_reset();
        idle();
        br = 1'b1; req = 1'b1; idv = 1'b1;
        #3;
        check("init_rst_fwd1", out1, 5'b0);
        check("init_rst_fwd0", out0, 5'b0);
        idle();
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        //             idv s1 s2 two wb ld dst br req rdy  exp1      exp0 chk1 chk0
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 3, 0, 0, 0, 5'b00000, 5'b0, 1, 0));
        tbl.push_back(mk(1, 3, 0, 0, 1, 0, 4, 0, 0, 0, 5'b10100, 5'b0, 1, 0));
        tbl.push_back(mk(1, 3, 0, 0, 1, 0, 4, 0, 0, 0, 5'b00000, 5'b0, 1, 0));
        tbl.push_back(mk(1, 4, 4, 1, 1, 0, 5, 0, 0, 0, 5'b00000, 5'b0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 1, 1, 6, 0, 0, 0, 5'b00000, 5'b0, 1, 0));
        tbl.push_back(mk(1, 0, 6, 1, 1, 1, 10, 1, 0, 0, 5'b01100, 5'b0, 1, 0));
        tbl.push_back(mk(1, 10, 0, 0, 1, 0, 8, 0, 0, 0, 5'b00000, 5'b0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 7, 0, 0, 0, 5'b00000, 5'b0, 1, 0));
        tbl.push_back(mk(0, 7, 0, 0, 1, 1, 9, 0, 0, 0, 5'b00000, 5'b0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 9, 0, 0, 0, 5'b00000, 5'b0, 1, 0));
        tbl.push_back(mk(1, 1, 9, 0, 1, 0, 1, 0, 0, 0, 5'b00000, 5'b0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 5'b00000, 5'b0, 1, 0));
        tbl.push_back(mk(1, 2, 0, 0, 1, 0, 3, 0, 0, 0, 5'b00000, 5'b0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b00000, 5'b0, 1, 0));
        tbl.push_back(mk(1, 3, 3, 1, 1, 0, 4, 1, 0, 0, 5'b01100, 5'b0, 1, 0));
        foreach (tbl[i]) step(tbl[i], $sformatf("tbl%0d", i));

        // Non-forwarding: ADD R2 then consumer on src2 stalls through EXE and MEM.
        reset_pulse("t2");
        step(mk(1, 0, 0, 0, 1, 0, 2, 0, 0, 0, 5'b00000, 5'b00000, 1, 1), "t2_add");
        for (int i = 0; i < 2; i++)
            step(mk(1, 7, 2, 1, 1, 0, 3, 0, 0, 0, 5'b00000, 5'b10100, 1, 1), $sformatf("t2_stall%0d", i));
        step(mk(1, 7, 2, 1, 1, 0, 3, 0, 0, 0, 5'b00000, 5'b00000, 1, 1), "t2_issue");

        // Memory wait of 3 cycles: slots must not advance while stalled.
        reset_pulse("t4");
        step(mk(1, 0, 0, 0, 1, 1, 5, 0, 0, 0, 5'b00000, 5'b00000, 1, 1), "t4_ldr");
        for (int i = 0; i < 3; i++)
            step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b10010, 5'b10010, 1, 1), $sformatf("t4_wait%0d", i));
        step(mk(1, 5, 0, 0, 1, 0, 6, 0, 1, 1, 5'b10100, 5'b10100, 1, 1), "t4_ready");
        step(mk(1, 5, 0, 0, 1, 0, 6, 0, 0, 0, 5'b00000, 5'b10100, 1, 1), "t4_after1");
        step(mk(1, 5, 0, 0, 1, 0, 6, 0, 0, 0, 5'b00000, 5'b00000, 1, 1), "t4_after2");

        // Timeout: WAIT_MAX+1 stall cycles, then sticky error until reset.
        reset_pulse("t5");
        for (int i = 1; i <= WM + 1; i++)
            step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b10010, 5'b10010, 1, 1), $sformatf("t5_wait%0d", i));
        for (int i = 0; i < 2; i++)
            step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b10011, 5'b10011, 1, 1), $sformatf("t5_err%0d", i));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b10011, 5'b10011, 1, 1), "t5_err_ready");
        reset_pulse("t5_clr");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 1, 1), "t5_post");

        // Reset asserted while in MEM_WAIT.
        reset_pulse("t6");
        for (int i = 0; i < 2; i++)
            step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b10010, 5'b10010, 1, 1), $sformatf("t6_wait%0d", i));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b0, 5'b0, 0, 0));
        reset_pulse("t6_mid");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 1, 1), "t6_post");
        step(mk(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 5'b00000, 5'b00000, 1, 1), "t6_issue");

        // Randomized traffic on a small register range to provoke frequent matches.
        reset_pulse("rnd");
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) reset_pulse("rnd_rst");
            v = mk($urandom_range(0, 3) != 0, W'($urandom_range(0, 3)), W'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   W'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                   1'($urandom_range(0, 1)), 5'b0, 5'b0, 0, 0);
            step(v, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
